// File: rtl/decode_if.sv
// Signal bundle between fetch, decode and execute. The slave modport is the
// decode side and the master modport is the side that drives it.
interface decode_if #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 32
);
    logic              valid_i;
    logic              ready_o;
    logic [AWIDTH-1:0] pc_i;
    logic [DWIDTH-1:0] insn_i;
    logic              flush_i;
    logic              valid_o;
    logic              ready_i;
    logic [AWIDTH-1:0] pc_o;
    logic [DWIDTH-1:0] insn_o;
    logic [6:0]        opcode_o;
    logic [4:0]        rd_o;
    logic [4:0]        rs1_o;
    logic [4:0]        rs2_o;
    logic [2:0]        funct3_o;
    logic [6:0]        funct7_o;
    logic [DWIDTH-1:0] imm_o;
    logic              illegal_o;

    modport slave (
        input  valid_i, pc_i, insn_i, flush_i, ready_i,
        output ready_o, valid_o, pc_o, insn_o, opcode_o, rd_o, rs1_o, rs2_o,
               funct3_o, funct7_o, imm_o, illegal_o
    );

    modport master (
        output valid_i, pc_i, insn_i, flush_i, ready_i,
        input  ready_o, valid_o, pc_o, insn_o, opcode_o, rd_o, rs1_o, rs2_o,
               funct3_o, funct7_o, imm_o, illegal_o
    );
endinterface

// File: rtl/decode.sv
// RV32I decode stage: splits a fetched word into register/function fields and a
// sign-extended immediate, held in one valid/ready pipeline register for execute.
module decode #(
    parameter int unsigned       DWIDTH   = 32,
    parameter int unsigned       AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = 32'h01000000
) (
    input  logic    clk,
    input  logic    rst,
    decode_if.slave bus
);
    typedef enum logic [6:0] {
        OP_LOAD     = 7'b0000011,
        OP_MISC_MEM = 7'b0001111,
        OP_IMM      = 7'b0010011,
        OP_AUIPC    = 7'b0010111,
        OP_STORE    = 7'b0100011,
        OP_OP       = 7'b0110011,
        OP_LUI      = 7'b0110111,
        OP_BRANCH   = 7'b1100011,
        OP_JALR     = 7'b1100111,
        OP_JAL      = 7'b1101111,
        OP_SYSTEM   = 7'b1110011
    } opcode_e;

    logic              valid_q;
    logic [AWIDTH-1:0] pc_q;
    logic [DWIDTH-1:0] insn_q;
    logic [DWIDTH-1:0] imm_q;
    logic              illegal_q;

    logic [DWIDTH-1:0] imm_d;
    logic              illegal_d;
    logic              ready;

    // No skid buffer: the register frees up whenever execute takes the bundle.
    assign ready = !valid_q || bus.ready_i;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        imm_d     = '0;
        illegal_d = 1'b0;
        case (bus.insn_i[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_MISC_MEM:
                imm_d = {{20{bus.insn_i[31]}}, bus.insn_i[31:20]};
            OP_STORE:
                imm_d = {{20{bus.insn_i[31]}}, bus.insn_i[31:25], bus.insn_i[11:7]};
            OP_BRANCH:
                imm_d = {{19{bus.insn_i[31]}}, bus.insn_i[31], bus.insn_i[7],
                         bus.insn_i[30:25], bus.insn_i[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm_d = {bus.insn_i[31:12], 12'b0};
            OP_JAL:
                imm_d = {{11{bus.insn_i[31]}}, bus.insn_i[31], bus.insn_i[19:12],
                         bus.insn_i[20], bus.insn_i[30:21], 1'b0};
            OP_OP:
                imm_d = '0;
            default:
                illegal_d = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            pc_q      <= BASEADDR;
            insn_q    <= '0;
            imm_q     <= '0;
            illegal_q <= 1'b0;
        end else if (bus.flush_i) begin
            valid_q <= 1'b0;
        end else if (ready) begin
            valid_q <= bus.valid_i;
            if (bus.valid_i) begin
                pc_q      <= bus.pc_i;
                insn_q    <= bus.insn_i;
                imm_q     <= imm_d;
                illegal_q <= illegal_d;
            end
        end
    end

    // Field outputs are raw slices of the registered word, so they inherit its
    // reset value and its hold/drain behaviour.
    assign bus.ready_o   = ready;
    assign bus.valid_o   = valid_q;
    assign bus.pc_o      = pc_q;
    assign bus.insn_o    = insn_q;
    assign bus.opcode_o  = insn_q[6:0];
    assign bus.rd_o      = insn_q[11:7];
    assign bus.funct3_o  = insn_q[14:12];
    assign bus.rs1_o     = insn_q[19:15];
    assign bus.rs2_o     = insn_q[24:20];
    assign bus.funct7_o  = insn_q[31:25];
    assign bus.imm_o     = imm_q;
    assign bus.illegal_o = illegal_q;
endmodule

// File: tb/tb_decode.sv
// Directed bench for the decode stage: format table, back-to-back stream,
// backpressure, drain, flush, illegal encodings and asynchronous reset.
module tb_decode;
    localparam logic [31:0] BASE = 32'h01000000;

    logic clk;
    logic rst;
    int   n_vec  = 0;
    int   n_miss = 0;

    decode_if #(.DWIDTH(32), .AWIDTH(32)) bus ();

    decode #(.DWIDTH(32), .AWIDTH(32), .BASEADDR(BASE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] insn;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] insn);
        bus.valid_i = v;
        bus.pc_i    = pc;
        bus.insn_i  = insn;
    endtask

    task automatic check_vec(input string tag, input vec_t e, input logic [31:0] pc);
        check({tag, ".valid"},   32'(bus.valid_o),   32'd1);
        check({tag, ".pc"},      bus.pc_o,           pc);
        check({tag, ".insn"},    bus.insn_o,         e.insn);
        check({tag, ".opcode"},  32'(bus.opcode_o),  32'(e.opc));
        check({tag, ".rd"},      32'(bus.rd_o),      32'(e.rd));
        check({tag, ".rs1"},     32'(bus.rs1_o),     32'(e.rs1));
        check({tag, ".rs2"},     32'(bus.rs2_o),     32'(e.rs2));
        check({tag, ".funct3"},  32'(bus.funct3_o),  32'(e.f3));
        check({tag, ".funct7"},  32'(bus.funct7_o),  32'(e.f7));
        check({tag, ".imm"},     bus.imm_o,          e.imm);
        check({tag, ".illegal"}, 32'(bus.illegal_o), 32'(e.ill));
    endtask

    initial begin
        //              insn          opc    rd     rs1    rs2    f3    f7     imm           ill
        vecs[0]  = '{32'h00500093, 7'h13, 5'd1,  5'd0,  5'd5,  3'd0, 7'h00, 32'h00000005, 1'b0}; // addi x1,x0,5
        vecs[1]  = '{32'h0020A423, 7'h23, 5'd8,  5'd1,  5'd2,  3'd2, 7'h00, 32'h00000008, 1'b0}; // sw x2,8(x1)
        vecs[2]  = '{32'hFE000EE3, 7'h63, 5'd29, 5'd0,  5'd0,  3'd0, 7'h7F, 32'hFFFFFFFC, 1'b0}; // beq x0,x0,-4
        vecs[3]  = '{32'h123452B7, 7'h37, 5'd5,  5'd8,  5'd3,  3'd5, 7'h09, 32'h12345000, 1'b0}; // lui x5,0x12345
        vecs[4]  = '{32'h0000006F, 7'h6F, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000, 1'b0}; // jal x0,0
        vecs[5]  = '{32'hFFF00093, 7'h13, 5'd1,  5'd0,  5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF, 1'b0}; // addi x1,x0,-1
        vecs[6]  = '{32'hFE112E23, 7'h23, 5'd28, 5'd2,  5'd1,  3'd2, 7'h7F, 32'hFFFFFFFC, 1'b0}; // sw x1,-4(x2)
        vecs[7]  = '{32'hFF9FF06F, 7'h6F, 5'd0,  5'd31, 5'd25, 3'd7, 7'h7F, 32'hFFFFFFF8, 1'b0}; // jal x0,-8
        vecs[8]  = '{32'h002081B3, 7'h33, 5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 32'h00000000, 1'b0}; // add x3,x1,x2
        vecs[9]  = '{32'hFFFFF097, 7'h17, 5'd1,  5'd31, 5'd31, 3'd7, 7'h7F, 32'hFFFFF000, 1'b0}; // auipc x1,0xFFFFF
        vecs[10] = '{32'h00000073, 7'h73, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000, 1'b0}; // ecall
        vecs[11] = '{32'h0000000B, 7'h0B, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000, 1'b1}; // custom-0
        vecs[12] = '{32'hFFFFFFFF, 7'h7F, 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 32'h00000000, 1'b1}; // all ones

        rst         = 1'b1;
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        step();
        step();
        check("rst.valid",   32'(bus.valid_o),   32'd0);
        check("rst.pc",      bus.pc_o,           BASE);
        check("rst.insn",    bus.insn_o,         32'h0);
        check("rst.opcode",  32'(bus.opcode_o),  32'h0);
        check("rst.rd",      32'(bus.rd_o),      32'h0);
        check("rst.imm",     bus.imm_o,          32'h0);
        check("rst.illegal", 32'(bus.illegal_o), 32'd0);
        check("rst.ready",   32'(bus.ready_o),   32'd1);
        rst = 1'b0;

        // Back-to-back stream through every format; valid_o must stay high.
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, BASE + 32'(4 * i), vecs[i].insn);
            step();
            check_vec($sformatf("stream%0d", i), vecs[i], BASE + 32'(4 * i));
        end

        // Drain: data outputs keep the last bundle.
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("drain.valid", 32'(bus.valid_o), 32'd0);
        check("drain.insn",  bus.insn_o,       vecs[12].insn);
        check("drain.ready", 32'(bus.ready_o), 32'd1);

        // Backpressure: second instruction waits while execute stalls.
        drive(1'b1, 32'h00002000, vecs[0].insn);
        step();
        check_vec("bp.first", vecs[0], 32'h00002000);
        drive(1'b1, 32'h00002004, vecs[1].insn);
        bus.ready_i = 1'b0;
        #1;
        check("bp.ready_low", 32'(bus.ready_o), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("bp.hold%0d.ready", c), 32'(bus.ready_o), 32'd0);
            check($sformatf("bp.hold%0d.valid", c), 32'(bus.valid_o), 32'd1);
            check($sformatf("bp.hold%0d.insn",  c), bus.insn_o,       vecs[0].insn);
            check($sformatf("bp.hold%0d.pc",    c), bus.pc_o,         32'h00002000);
            check($sformatf("bp.hold%0d.imm",   c), bus.imm_o,        vecs[0].imm);
        end
        bus.ready_i = 1'b1;
        step();
        check_vec("bp.second", vecs[1], 32'h00002004);
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("bp.nodup.valid", 32'(bus.valid_o), 32'd0);

        // Flush drops the incoming word; the next accept works normally.
        drive(1'b1, 32'h00003000, vecs[0].insn);
        step();
        check("fl.pre.valid", 32'(bus.valid_o), 32'd1);
        drive(1'b1, 32'h00003004, vecs[1].insn);
        bus.flush_i = 1'b1;
        #1;
        check("fl.ready", 32'(bus.ready_o), 32'd1);
        step();
        bus.flush_i = 1'b0;
        check("fl.valid", 32'(bus.valid_o), 32'd0);
        check("fl.insn",  bus.insn_o,       vecs[0].insn);
        drive(1'b1, 32'h00003008, vecs[3].insn);
        step();
        check_vec("fl.after", vecs[3], 32'h00003008);

        // Asynchronous reset in the middle of a hold.
        drive(1'b1, 32'h0000300C, vecs[1].insn);
        bus.ready_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst.valid", 32'(bus.valid_o), 32'd0);
        check("arst.pc",    bus.pc_o,         BASE);
        check("arst.imm",   bus.imm_o,        32'h0);
        check("arst.insn",  bus.insn_o,       32'h0);
        check("arst.ready", 32'(bus.ready_o), 32'd1);
        rst = 1'b0;
        bus.ready_i = 1'b1;
        drive(1'b1, 32'h00004000, vecs[9].insn);
        step();
        check_vec("arst.first", vecs[9], 32'h00004000);
        drive(1'b0, 32'h0, 32'h0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/decode.md
Name: decode

Overview:
- RV32I decode stage, directly downstream of the fetch stage.
- Accepts a fetched instruction word and its PC through a valid/ready handshake.
- Splits the word into register indices and function fields, and generates the sign-extended immediate.
- Holds the result in a single pipeline register that feeds execute; flags unsupported encodings.

Parameters:
- DWIDTH, 32, instruction/immediate width (only 32 supported)
- AWIDTH, 32, PC width
- BASEADDR, 32'h01000000, reset value of pc_o

Ports:
- clk  input  1  clock, rising-edge
- rst  input  1  reset, asynchronous, active-high
- valid_i  input  1  fetch presents a valid instruction
- ready_o  output  1  decode can accept this cycle
- pc_i  input  AWIDTH  PC of incoming instruction
- insn_i  input  DWIDTH  incoming instruction word
- flush_i  input  1  discard held and incoming instruction (redirect)
- valid_o  output  1  decoded bundle valid
- ready_i  input  1  execute accepts bundle
- pc_o  output  AWIDTH  registered PC
- insn_o  output  DWIDTH  registered raw instruction
- opcode_o  output  7  insn[6:0]
- rd_o  output  5  insn[11:7]
- rs1_o  output  5  insn[19:15]
- rs2_o  output  5  insn[24:20]
- funct3_o  output  3  insn[14:12]
- funct7_o  output  7  insn[31:25]
- imm_o  output  DWIDTH  generated immediate
- illegal_o  output  1  unsupported opcode

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous and active-high.
- Reset values:
  - valid_o=0, pc_o=BASEADDR, insn_o=0, imm_o=0, illegal_o=0
  - all field outputs 0
- ready_o is combinational: ready_o = !valid_o || ready_i.
  - Full throughput; no skid buffer. Depends on ready_i, not on valid_i.
- Accept: valid_i && ready_o at a rising edge.
  - All outputs load from pc_i/insn_i and decode logic in that edge.
  - valid_o=1. Latency is 1 cycle.
- Hold: valid_o && !ready_i.
  - All outputs stable; no input accepted.
- Drain: valid_o && ready_i && !valid_i → valid_o=0 next cycle. Data outputs retain their last values.
- Back-to-back: valid_o && ready_i && valid_i → new bundle loads; valid_o stays 1.
- Flush has priority over everything:
  - flush_i=1 at an edge → valid_o=0. The incoming instruction is not captured.
  - ready_o is still computed normally.
  - Data regs may hold stale values; consumers qualify them with valid_o.
- Immediate, by opcode (sext = sign-extend from the top bit shown):
  - I-type (0010011, 0000011, 1100111, 1110011, 0001111): sext(insn[31:20])
  - S-type (0100011): sext({insn[31:25],insn[11:7]})
  - B-type (1100011): sext({insn[31],insn[7],insn[30:25],insn[11:8],1'b0})
  - U-type (0110111, 0010111): {insn[31:12],12'b0}
  - J-type (1101111): sext({insn[31],insn[19:12],insn[20],insn[30:21],1'b0})
  - R-type (0110011): 0
- illegal_o=1 for any opcode outside the list above, including insn[1:0]!=2'b11.
  - In that case imm_o=0; fields still pass through raw. valid_o is asserted as normal.
- Field outputs are raw bit slices regardless of format; no masking of unused fields.
- Reset asserted mid-hold or mid-stream: outputs return to reset values immediately (async).
  - The first accept is possible on the first edge after rst deasserts.

Test Plan:
- Reset: rst=1 mid-run with valid_o=1 → valid_o=0, pc_o=0x01000000, imm_o=0 without waiting for a clock edge; ready_o=1.
- Single accept, I-type: insn_i=0x00500093 (addi x1,x0,5), pc_i=0x01000000, ready_i=1.
  - Next cycle: valid_o=1, opcode_o=0x13, rd_o=1, rs1_o=0, funct3_o=0, imm_o=0x00000005, illegal_o=0.
- Formats, back-to-back with ready_i=1:
  - 0x0020A423 (sw x2,8(x1)) → imm_o=8, rs1_o=1, rs2_o=2
  - 0xFE000EE3 (beq x0,x0,-4) → imm_o=0xFFFFFFFC
  - 0x123452B7 (lui x5,0x12345) → imm_o=0x12345000, rd_o=5
  - 0x0000006F (jal x0,0) → imm_o=0
  - valid_o held 1 for 4 consecutive cycles.
- Backpressure: accept 0x00500093, hold ready_i=0 for 3 cycles while valid_i=1 with insn_i=0x0020A423.
  - During the hold: ready_o=0 and outputs stable.
  - After ready_i=1: second instruction appears one cycle later; no loss or duplication.
- Flush: valid_o=1 and valid_i=1 with flush_i=1 for one cycle → valid_o=0 next cycle and the incoming insn is not captured. A following accept works normally.
- Illegal: insn_i=0x0000000B → valid_o=1, illegal_o=1, imm_o=0. insn_i=0xFFFFFFFF → illegal_o=1.
